data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
Load/store responder on the memory side of the decoder's MemRead/MemWrite/BE/funct3 control bundle. Accepts one CPU data request at a time and drives a synchronous single-port byte-writable SRAM (one-cycle read latency). Splits accesses that straddle a word boundary into two word accesses. Returns load data right-aligned and sign- or zero-extended per funct3.

Parameters:
MEM_AW, 10, SRAM word-address width; byte address bits [MEM_AW+1:2] select the word, higher bits are ignored.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; a request is taken when req_valid && req_ready
req_write  in  1  1 = store (MemWrite), 0 = load
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, right-aligned (rs2)
req_be  in  4  decoder BE: 0001 byte, 0011 half, 1111 word
req_funct3  in  3  load extension select
rsp_valid  out  1  one-cycle pulse: request complete
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid; illegal BE or load funct3
mem_cs  out  1  SRAM access strobe
mem_we  out  1  SRAM write
mem_addr  out  MEM_AW  SRAM word address
mem_wdata  out  32  SRAM write data
mem_bwe  out  4  SRAM byte write enables
mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (async, any state): state=IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_cs=0, mem_we=0, mem_bwe=0, mem_addr=0, mem_wdata=0. The latched request and capture registers clear to 0. Reset mid-access abandons the access and produces no response.
- States: IDLE, ACC0, ACC1, WAIT, RESP.
- IDLE: req_ready=1. On handshake, latch the request.
  - Error if req_be is not one of {0001, 0011, 1111}, or if it is a load with funct3 not in {000, 001, 010, 100, 101}. Error goes to RESP with no SRAM access.
  - Otherwise go to ACC0.
- Lane math: off = addr[1:0]; be8 = {4'b0, be} << off; wd64 = {32'b0, wdata} << (8*off). split = (be8[7:4] != 0). w0 = addr[MEM_AW+1:2]; w1 = w0 + 1, modulo 2^MEM_AW (wraps to 0 at top).
- ACC0: mem_cs=1, mem_addr=w0, mem_we=write.
  - Stores: mem_bwe=be8[3:0], mem_wdata=wd64[31:0].
  - Next state: ACC1 if split; else WAIT for loads, RESP for stores.
- ACC1: mem_cs=1, mem_addr=w1, mem_bwe=be8[7:4], mem_wdata=wd64[63:32]. Loads capture mem_rdata as lo. Next state: WAIT for loads, RESP for stores.
- WAIT (loads only): mem_cs=0. Capture mem_rdata as hi if split, else as lo. Next state: RESP.
- Load result: r = ({hi, lo} >> 8*off)[31:0], where hi=0 when not split. Extension:
  - 000: sign-extend r[7:0]
  - 100: zero-extend r[7:0]
  - 001: sign-extend r[15:0]
  - 101: zero-extend r[15:0]
  - 010: r
- RESP: rsp_valid=1 for exactly one cycle. rsp_rdata and rsp_err are registered and valid only in this cycle, 0 otherwise. Next state: IDLE.
- mem_we and mem_bwe are 0 whenever mem_cs=0 or the access is a load.
- Latency, handshake cycle to rsp_valid:
  - aligned load: 3
  - split load: 4
  - aligned store: 2
  - split store: 3
  - error: 1
- Back-to-back: the next request is accepted in the IDLE cycle after RESP. req_valid asserted outside IDLE is ignored and not latched.

Test Plan:
- Aligned LW: mem[0x10]=0xDEADBEEF, addr=0x40, be=1111, f3=010 -> one read strobe at word 0x10, rsp_valid 3 cycles after handshake, rdata=0xDEADBEEF, err=0.
- LB vs LBU: mem[0x10]=0x80FF7F01, addr=0x43 -> f3=000 gives 0xFFFFFF80, f3=100 gives 0x00000080.
- Split LH: mem[0x10]=0xAB000000, mem[0x11]=0x000000CD, addr=0x43, f3=001 -> two strobes (0x10, 0x11), rdata=0xFFFFCDAB, latency 4.
- Split SW at addr=0x42, wdata=0x11223344 -> word 0x10 bwe=1100, wdata=0x33440000; word 0x11 bwe=0011, wdata=0x00001122; rsp_valid 3 cycles after handshake.
- Wrap: MEM_AW=10, SW at addr=0xFFE -> second access at word 0x000, bwe=0011. Illegal be=0101 -> rsp_err=1 after 1 cycle, mem_cs never asserted.
- Assert RST during ACC1 of a split load -> all outputs 0 immediately, no rsp_valid; after release, a fresh aligned LW completes normally.

Source files
------------

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-outstanding load/store unit driving a byte-writable synchronous SRAM,
// splitting word-straddling accesses and returning right-aligned, extended load data.
module data_mem_lsu #(
  parameter int MEM_AW = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_bwe,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic              r_write, r_err;
  logic [1:0]        r_off;
  logic [MEM_AW-1:0] r_word;
  logic [31:0]       r_wdata, r_lo, r_rdata;
  logic [3:0]        r_be;
  logic [2:0]        r_f3;
  logic              w_take, w_bad, w_split, w_acc0, w_acc1, w_unused;
  logic [7:0]        w_be8;
  logic [63:0]       w_wd64, w_ld64;
  logic [31:0]       w_lo, w_hi, w_r, w_ext;
  logic [MEM_AW-1:0] w_w1;
  assign w_unused = ^req_addr[31:MEM_AW+2];
  assign w_take = req_valid && r_state == IDLE;
  assign w_bad = !(req_be == 4'b0001 || req_be == 4'b0011 || req_be == 4'b1111) ||
                 (!req_write && !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                                  req_funct3 == 3'b010 || req_funct3 == 3'b100 ||
                                  req_funct3 == 3'b101));
  assign w_be8 = {4'b0, r_be} << r_off;
  assign w_wd64 = {32'b0, r_wdata} << {r_off, 3'b000};
  assign w_split = |w_be8[7:4];
  assign w_w1 = r_word + MEM_AW'(1);
  // In WAIT the live read data is the second word for split loads, else the only word.
  assign w_lo = w_split ? r_lo : mem_rdata;
  assign w_hi = w_split ? mem_rdata : 32'b0;
  assign w_ld64 = {w_hi, w_lo} >> {r_off, 3'b000};
  assign w_r = w_ld64[31:0];
  assign w_ext = r_f3 == 3'b000 ? {{24{w_r[7]}}, w_r[7:0]} :
                 r_f3 == 3'b100 ? {24'b0, w_r[7:0]} :
                 r_f3 == 3'b001 ? {{16{w_r[15]}}, w_r[15:0]} :
                 r_f3 == 3'b101 ? {16'b0, w_r[15:0]} : w_r;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = req_valid ? (w_bad ? RESP : ACC0) : IDLE;
      ACC0: w_next = w_split ? ACC1 : (r_write ? RESP : WAIT);
      ACC1: w_next = r_write ? RESP : WAIT;
      WAIT: w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign w_acc0 = r_state == ACC0;
  assign w_acc1 = r_state == ACC1;
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err = r_err;
  assign mem_cs = w_acc0 || w_acc1;
  assign mem_we = mem_cs && r_write;
  assign mem_addr = w_acc0 ? r_word : w_acc1 ? w_w1 : '0;
  assign mem_bwe = !mem_we ? 4'b0 : w_acc0 ? w_be8[3:0] : w_be8[7:4];
  assign mem_wdata = !mem_we ? 32'b0 : w_acc0 ? w_wd64[31:0] : w_wd64[63:32];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_off   <= '0;
      r_word  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_f3    <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_write <= req_write;
        r_off   <= req_addr[1:0];
        r_word  <= req_addr[MEM_AW+1:2];
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_f3    <= req_funct3;
      end
      if (w_acc1 && !r_write) r_lo <= mem_rdata;
      r_rdata <= (r_state == WAIT) ? w_ext : 32'b0;
      r_err   <= w_take && w_bad;
    end
  end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed bench with a behavioural SRAM, strobe monitor and
// hand-computed expectations for loads, stores, splits, wrap, errors and reset.
module tb_data_mem_lsu;
  logic        CLK = 0, RST = 1;
  logic        req_valid = 0, req_write = 0, req_ready;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic [2:0]  req_funct3 = 0;
  logic        rsp_valid, rsp_err, mem_cs, mem_we;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_bwe;
  logic [31:0] mem [0:1023];
  int          n_chk = 0, n_fail = 0, ns = 0, nrsp = 0, base, lat, nstb, rsp0;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [9:0]  s_addr [0:63];
  logic [3:0]  s_bwe [0:63];
  logic [31:0] s_wd [0:63];
  logic        s_we [0:63];

  data_mem_lsu #(.MEM_AW(10)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_funct3(req_funct3), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bwe(mem_bwe), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_cs) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_bwe[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge CLK) begin
    if (mem_cs) begin
      s_addr[ns % 64] = mem_addr;
      s_bwe[ns % 64]  = mem_bwe;
      s_wd[ns % 64]   = mem_wdata;
      s_we[ns % 64]   = mem_we;
      ns++;
    end
    if (rsp_valid) nrsp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [2:0] f3);
    @(negedge CLK);
    chk("req_ready", 32'(req_ready), 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be; req_funct3 = f3;
    base = ns;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    got_rdata = rsp_rdata;
    got_err = rsp_err;
    nstb = ns - base;
  endtask

  initial begin
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mem_cs", 32'(mem_cs), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_bwe", 32'(mem_bwe), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(negedge CLK);
    RST = 0;

    req(1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b010);
    chk("sw_lat", lat, 2);
    chk("sw_nstb", nstb, 1);
    chk("sw_addr", 32'(s_addr[base % 64]), 32'h10);
    chk("sw_bwe", 32'(s_bwe[base % 64]), 32'hF);
    chk("sw_wdata", s_wd[base % 64], 32'hDEADBEEF);
    chk("sw_err", 32'(got_err), 0);

    req(0, 32'h40, 0, 4'hF, 3'b010);
    chk("lw_lat", lat, 3);
    chk("lw_rdata", got_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(got_err), 0);
    chk("lw_nstb", nstb, 1);
    chk("lw_addr", 32'(s_addr[base % 64]), 32'h10);
    chk("lw_we", 32'(s_we[base % 64]), 0);
    chk("lw_bwe", 32'(s_bwe[base % 64]), 0);

    req(1, 32'h40, 32'h80FF7F01, 4'hF, 3'b010);
    req(0, 32'h43, 0, 4'h1, 3'b000);
    chk("lb_rdata", got_rdata, 32'hFFFFFF80);
    req(0, 32'h43, 0, 4'h1, 3'b100);
    chk("lbu_rdata", got_rdata, 32'h00000080);
    req(0, 32'h41, 0, 4'h1, 3'b000);
    chk("lb_pos_rdata", got_rdata, 32'h0000007F);

    req(1, 32'h40, 32'hAB000000, 4'hF, 3'b010);
    req(1, 32'h44, 32'h000000CD, 4'hF, 3'b010);
    req(0, 32'h43, 0, 4'h3, 3'b001);
    chk("lh_split_lat", lat, 4);
    chk("lh_split_rdata", got_rdata, 32'hFFFFCDAB);
    chk("lh_split_nstb", nstb, 2);
    chk("lh_split_a0", 32'(s_addr[base % 64]), 32'h10);
    chk("lh_split_a1", 32'(s_addr[(base + 1) % 64]), 32'h11);

    req(1, 32'h42, 32'h11223344, 4'hF, 3'b010);
    chk("sw_split_lat", lat, 3);
    chk("sw_split_nstb", nstb, 2);
    chk("sw_split_a0", 32'(s_addr[base % 64]), 32'h10);
    chk("sw_split_bwe0", 32'(s_bwe[base % 64]), 32'hC);
    chk("sw_split_wd0", s_wd[base % 64], 32'h33440000);
    chk("sw_split_a1", 32'(s_addr[(base + 1) % 64]), 32'h11);
    chk("sw_split_bwe1", 32'(s_bwe[(base + 1) % 64]), 32'h3);
    chk("sw_split_wd1", s_wd[(base + 1) % 64], 32'h00001122);

    req(0, 32'h42, 0, 4'hF, 3'b010);
    chk("lw_split_lat", lat, 4);
    chk("lw_split_rdata", got_rdata, 32'h11223344);
    req(0, 32'h42, 0, 4'h3, 3'b101);
    chk("lhu_lat", lat, 3);
    chk("lhu_rdata", got_rdata, 32'h00003344);
    chk("lhu_nstb", nstb, 1);

    req(1, 32'hFFE, 32'hA5A55A5A, 4'hF, 3'b010);
    chk("wrap_a0", 32'(s_addr[base % 64]), 32'h3FF);
    chk("wrap_bwe0", 32'(s_bwe[base % 64]), 32'hC);
    chk("wrap_a1", 32'(s_addr[(base + 1) % 64]), 32'h000);
    chk("wrap_bwe1", 32'(s_bwe[(base + 1) % 64]), 32'h3);
    chk("wrap_wd1", s_wd[(base + 1) % 64], 32'h0000A5A5);
    req(0, 32'hFFE, 0, 4'hF, 3'b010);
    chk("wrap_ld_rdata", got_rdata, 32'hA5A55A5A);

    req(1, 32'h40, 32'h12345678, 4'h5, 3'b010);
    chk("bad_be_err", 32'(got_err), 1);
    chk("bad_be_lat", lat, 1);
    chk("bad_be_nstb", nstb, 0);
    chk("bad_be_rdata", got_rdata, 0);
    req(0, 32'h40, 0, 4'hF, 3'b011);
    chk("bad_f3_err", 32'(got_err), 1);
    chk("bad_f3_lat", lat, 1);
    chk("bad_f3_nstb", nstb, 0);

    @(negedge CLK);
    req_valid = 1; req_write = 0; req_addr = 32'h43; req_be = 4'h3; req_funct3 = 3'b001;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 0;
    @(negedge CLK);
    chk("acc1_cs", 32'(mem_cs), 1);
    chk("acc1_addr", 32'(mem_addr), 32'h11);
    rsp0 = nrsp;
    RST = 1;
    #1;
    chk("mid_rst_cs", 32'(mem_cs), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    repeat (2) @(negedge CLK);
    RST = 0;
    repeat (4) @(negedge CLK);
    chk("mid_rst_no_rsp", nrsp - rsp0, 0);
    req(0, 32'h40, 0, 4'hF, 3'b010);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", got_rdata, 32'h33440000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
